ticket_fifo_ctrl: RTL and testbench
===================================

// Module: ticket_fifo_ctrl
// PURPOSE
//  Pointer/flow-control wrapper for the 1-cycle-latency ticket RAM (write-through on same-address rd/wr).
//  Upstream producer pushes tickets over valid/ready. Block drives RAM write/read ports and re-times q
//  through a 2-entry output buffer. Downstream scheduler pops over valid/ready at 1 ticket/cycle, no bubbles.
// PARAMETERS
//  DATA_WIDTH  68  ticket width; equals RAM data width
//  ADDR_WIDTH  4   RAM address width; RAM_DEPTH = 2**ADDR_WIDTH
//  AFULL_LVL   12  almost_full asserted when fill_level >= AFULL_LVL
// PORTS
//  clk          in   1             single clock; all logic on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  flush        in   1             synchronous clear of all contents
//  in_data      in   DATA_WIDTH    ticket from producer
//  in_valid     in   1             producer has ticket
//  in_ready     out  1             RAM has free slot (registered)
//  out_data     out  DATA_WIDTH    head ticket (registered)
//  out_valid    out  1             head ticket valid
//  out_ready    in   1             consumer takes head ticket
//  ram_wdata    out  DATA_WIDTH    = in_data
//  ram_waddr    out  ADDR_WIDTH    write pointer, low bits
//  ram_raddr    out  ADDR_WIDTH    read pointer, low bits
//  ram_we       out  1             = push
//  ram_q        in   DATA_WIDTH    RAM registered read data
//  fill_level   out  ADDR_WIDTH+2  RAM entries + in-flight read + output-buffer entries
//  almost_full  out  1             fill_level >= AFULL_LVL (registered)
// BEHAVIOUR
//  Reset: pointers, ram_count, inflight, buffer occupancy, fill_level = 0. out_valid, in_ready, almost_full = 0.
//   in_ready rises on the first clk edge after rst_n release.
//  push = in_valid & in_ready; pop = out_valid & out_ready.
//  in_ready = (ram_count < RAM_DEPTH), registered. No combinational path from out_ready.
//  Pointers are ADDR_WIDTH+1 bits. Wrap is modulo 2**(ADDR_WIDTH+1); the low bits address the RAM.
//  Read issue (rd): (ram_count>0 | push) & (buf_occ + inflight - pop < 2). ram_raddr = rd_ptr; rd_ptr++ on rd.
//   Cut-through: if ram_count==0 and push, rd issues in the same cycle at rd_ptr==wr_ptr.
//   RAM write-through then returns in_data on ram_q one edge later.
//  inflight <= rd. When inflight==1, ram_q is written into the output buffer at the next edge.
//  ram_count' = ram_count + push - rd. Simultaneous push/rd leaves it unchanged. Never exceeds RAM_DEPTH.
//  Output buffer: 2 entries, FIFO order, head -> out_data/out_valid.
//   A pop and an ram_q load in the same cycle are both honoured.
//  Latency: push at edge n into an empty block gives out_valid=1 after edge n+1.
//   Sustained push+pop gives 1 ticket/cycle throughput.
//  Capacity: RAM_DEPTH + 2. fill_level' = fill_level + push - pop.
//  flush (highest priority after reset): all state cleared as at reset, except in_ready=1 after the edge.
//   Any ram_q returning next cycle is discarded. push and pop in the flush cycle are ignored.
//  out_data holds its value while out_valid & !out_ready (AXI-style stable).
//  Reset mid-operation: everything cleared asynchronously; RAM contents are don't-care.
// STRUCTURE
//  Shared package packet_scheduler_pkg: TICKET_W (68), TICKET_FIFO_AW (4), ticket field offsets.
//  Sub-module ticket_skid2: 2-entry valid/ready output buffer with load/pop ports and an occupancy output.
//  Top level holds pointers, counters, rd/push logic and RAM port muxing. The RAM is instantiated by the parent.
// TESTING (bench uses behavioural 1-cycle RAM model with write-through)
//  1 Reset: hold rst_n=0 3 cycles -> out_valid=0, in_ready=0, fill_level=0. First edge after release -> in_ready=1.
//  2 Cut-through: push 0xA5 into empty block at edge n, out_ready=1 -> out_valid=1, out_data=0xA5 after n+1,
//    ram_raddr==ram_waddr in the push cycle.
//  3 Fill: push 18 tickets 1..18, out_ready=0 -> in_ready=0 after 18th. fill_level=18.
//    19th in_valid ignored. Pop all -> 1..18 in order.
//  4 Streaming: in_valid=out_ready=1 for 100 cycles -> 1 ticket/cycle, no gaps after first output, order preserved.
//  5 Backpressure: random out_ready 50% with random in_valid, 10k cycles -> scoreboard match, no loss or duplication,
//    fill_level always equals model.
//  6 Flush: flush with 7 queued and a read in flight -> next cycle out_valid=0, fill_level=0.
//    Then push 0x3C -> out_data=0x3C, not stale data.

Source files
------------

// File: rtl/packet_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// packet_scheduler_pkg
// Shared definitions for the packet scheduler ticket path: ticket width,
// ticket FIFO RAM address width, ticket field layout, and the small types
// used by the ticket FIFO controller and its output buffer.
// No ports (package).
// -----------------------------------------------------------------------------
package packet_scheduler_pkg;

    // Ticket and ticket-RAM geometry
    localparam int TICKET_W       = 68;
    localparam int TICKET_FIFO_AW = 4;

    // Ticket field offsets (LSB position and width of each field)
    localparam int TKT_LEN_LSB  = 0;
    localparam int TKT_LEN_W    = 8;
    localparam int TKT_PTR_LSB  = 8;
    localparam int TKT_PTR_W    = 32;
    localparam int TKT_SEQ_LSB  = 40;
    localparam int TKT_SEQ_W    = 16;
    localparam int TKT_PRIO_LSB = 56;
    localparam int TKT_PRIO_W   = 4;
    localparam int TKT_FLOW_LSB = 60;
    localparam int TKT_FLOW_W   = 8;

    // Packed view of a ticket; field order matches the offsets above
    typedef struct packed {
        logic [TKT_FLOW_W-1:0] flow_id;
        logic [TKT_PRIO_W-1:0] prio;
        logic [TKT_SEQ_W-1:0]  seq;
        logic [TKT_PTR_W-1:0]  buf_ptr;
        logic [TKT_LEN_W-1:0]  len;
    } ticket_t;

    // Operation applied to the 2-entry output buffer in a given cycle
    typedef enum logic [1:0] {
        SKID_HOLD = 2'b00,
        SKID_LOAD = 2'b01,
        SKID_POP  = 2'b10,
        SKID_SWAP = 2'b11
    } skid_op_e;

    // Number of RAM words for a given address width
    function automatic int ram_depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ticket_skid2.sv
// -----------------------------------------------------------------------------
// ticket_skid2
// Two-entry FIFO-ordered output buffer between the ticket RAM read data and
// the downstream scheduler. Entry 0 is always the head and drives the output
// directly from a register. A load and a pop in the same cycle are both
// honoured, which keeps the path at one ticket per cycle.
//
// Ports
//   clk        in   1           clock, posedge
//   rst_n      in   1           asynchronous active-low reset
//   flush      in   1           synchronous clear (empties the buffer)
//   load       in   1           write load_data behind the current contents
//   load_data  in   DATA_WIDTH  ticket to store
//   pop        in   1           remove the head (only asserted while valid)
//   head_data  out  DATA_WIDTH  head ticket (registered)
//   head_valid out  1           head ticket present
//   occ        out  2           number of stored tickets (0..2)
// -----------------------------------------------------------------------------
module ticket_skid2
    import packet_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = TICKET_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;
    logic [1:0]            occ_q;
    skid_op_e              op;

    always_comb begin
        op = SKID_HOLD;
        unique case ({pop, load})
            2'b01:   op = SKID_LOAD;
            2'b10:   op = SKID_POP;
            2'b11:   op = SKID_SWAP;
            default: op = SKID_HOLD;
        endcase
    end

    // The controller never loads a full buffer (it reserves space before
    // issuing a RAM read), so LOAD only sees occupancy 0 or 1.
    // On SWAP with one entry the new ticket replaces the departing head;
    // with two entries the second slot moves up and the new ticket fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0  <= '0;
            ent1  <= '0;
            occ_q <= 2'd0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            unique case (op)
                SKID_LOAD: begin
                    if (occ_q == 2'd0) begin
                        ent0 <= load_data;
                    end else begin
                        ent1 <= load_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                SKID_POP: begin
                    ent0  <= ent1;
                    occ_q <= occ_q - 2'd1;
                end
                SKID_SWAP: begin
                    if (occ_q == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= load_data;
                    end else begin
                        ent0 <= load_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head_data  = ent0;
    assign head_valid = (occ_q != 2'd0);
    assign occ        = occ_q;

endmodule

// File: rtl/ticket_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// ticket_fifo_ctrl
// Pointer and flow-control wrapper around an external 1-cycle-latency ticket
// RAM (write-through on same-address read/write). Producer pushes over
// valid/ready; the block writes the RAM, issues reads so that at most two
// tickets are in the output buffer or in flight, and re-times ram_q through
// ticket_skid2. The consumer pops one ticket per cycle with no bubbles.
// Total capacity is RAM_DEPTH + 2.
//
// Ports
//   clk          in   1             clock, posedge
//   rst_n        in   1             asynchronous active-low reset
//   flush        in   1             synchronous clear of all contents
//   in_data      in   DATA_WIDTH    ticket from producer
//   in_valid     in   1             producer has a ticket
//   in_ready     out  1             RAM has a free slot (registered)
//   out_data     out  DATA_WIDTH    head ticket (registered)
//   out_valid    out  1             head ticket valid
//   out_ready    in   1             consumer takes the head ticket
//   ram_wdata    out  DATA_WIDTH    RAM write data (= in_data)
//   ram_waddr    out  ADDR_WIDTH    RAM write address
//   ram_raddr    out  ADDR_WIDTH    RAM read address
//   ram_we       out  1             RAM write enable (= push)
//   ram_q        in   DATA_WIDTH    RAM registered read data
//   fill_level   out  ADDR_WIDTH+2  RAM entries + in-flight read + buffer
//   almost_full  out  1             fill_level >= AFULL_LVL (registered)
// -----------------------------------------------------------------------------
module ticket_fifo_ctrl
    import packet_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = TICKET_W,
    parameter int ADDR_WIDTH = TICKET_FIFO_AW,
    parameter int AFULL_LVL  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic [ADDR_WIDTH+1:0] fill_level,
    output logic                  almost_full
);

    localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH);
    localparam int PW        = ADDR_WIDTH + 1;
    localparam int FW        = ADDR_WIDTH + 2;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] ram_count;
    logic [PW-1:0] ram_count_next;
    logic [FW-1:0] fill_next;
    logic          inflight;
    logic          push;
    logic          pop;
    logic          rd;
    logic [1:0]    buf_occ;
    logic [2:0]    claim;
    logic          buf_load;

    // Handshakes. Both are ignored in a flush cycle so nothing is written
    // to the RAM or removed from the buffer while everything is cleared.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // A read may only be issued if its data will have a buffer slot when it
    // returns: slots already claimed are buffered tickets plus the read in
    // flight, minus the one leaving this cycle. With an empty RAM and a
    // push, the read goes to the address being written and the RAM's
    // write-through returns the new ticket next cycle (cut-through).
    always_comb begin
        claim          = {1'b0, buf_occ} + {2'b00, inflight};
        rd             = ~flush & ((ram_count != '0) | push)
                         & (claim < (3'd2 + {2'b00, pop}));
        ram_count_next = ram_count + PW'(push) - PW'(rd);
        fill_next      = fill_level + FW'(push) - FW'(pop);
    end

    // Pointers, occupancy counters and the registered status flags.
    // in_ready is computed from the next RAM count so a full RAM blocks
    // the producer on the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            inflight    <= 1'b0;
            fill_level  <= '0;
            in_ready    <= 1'b0;
            almost_full <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            inflight    <= 1'b0;
            fill_level  <= '0;
            in_ready    <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            ram_count   <= ram_count_next;
            inflight    <= rd;
            fill_level  <= fill_next;
            in_ready    <= (ram_count_next < PW'(RAM_DEPTH));
            almost_full <= (fill_next >= FW'(AFULL_LVL));
        end
    end

    // Data returning from a read issued last cycle. Gated by flush so a
    // read that was in flight during a flush is dropped.
    assign buf_load = inflight & ~flush;

    ticket_skid2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (buf_load),
        .load_data (ram_q),
        .pop       (pop),
        .head_data (out_data),
        .head_valid(out_valid),
        .occ       (buf_occ)
    );

    // RAM port connections
    assign ram_wdata = in_data;
    assign ram_waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
    assign ram_we    = push;

endmodule

// File: tb/tb_ticket_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ticket_fifo_ctrl
// Bench for ticket_fifo_ctrl with a behavioural write-through RAM. The
// reference model is a queue of tickets tagged with the edge at which they
// were pushed: a ticket is visible at the head one edge after its push edge,
// the block holds at most RAM depth + 2 tickets, and the producer is stalled
// exactly when the block is at that capacity.
// -----------------------------------------------------------------------------
module tb_ticket_fifo_ctrl;

    localparam int DW    = 68;
    localparam int AW    = 4;
    localparam int FW    = AW + 2;
    localparam int DEPTH = 16;
    localparam int CAP   = DEPTH + 2;
    localparam int AFULL = 12;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_waddr;
    logic [AW-1:0] ram_raddr;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [FW-1:0] fill_level;
    logic          almost_full;

    ticket_fifo_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_LVL (AFULL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ram_wdata  (ram_wdata),
        .ram_waddr  (ram_waddr),
        .ram_raddr  (ram_raddr),
        .ram_we     (ram_we),
        .ram_q      (ram_q),
        .fill_level (fill_level),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-cycle RAM with write-through on same-address access
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        ram_q <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : mem[ram_raddr];
    end

    // Reference model state
    logic [DW-1:0] mdl_q[$];
    int            mdl_t[$];
    int            edge_cnt;
    bit            mdl_rdy;
    int            mdl_wptr;
    bit            cur_push;
    bit            cur_pop;
    logic [DW-1:0] cur_data;

    int errors;
    int checks;

    task automatic checkOutput(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic bit mdl_valid();
        return (mdl_q.size() > 0) && (mdl_t[0] < edge_cnt);
    endfunction

    // Drive one cycle of inputs (called just after a falling edge) and check
    // the RAM write port against the model's idea of this cycle's push.
    task automatic applyStimulus(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cur_data  = d;
        cur_push  = rst_n && !fl && iv && mdl_rdy;
        cur_pop   = rst_n && !fl && ordy && mdl_valid();
        #1;
        checkOutput("ram_we", DW'(ram_we), DW'(cur_push));
        if (cur_push) begin
            checkOutput("ram_wdata", ram_wdata, d);
            checkOutput("ram_waddr", DW'(ram_waddr), DW'(mdl_wptr));
        end
    endtask

    // Advance the model over the rising edge, then check all outputs at the
    // following falling edge.
    task automatic commitCycle();
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            mdl_q.delete();
            mdl_t.delete();
            mdl_rdy  = 1'b0;
            mdl_wptr = 0;
        end else if (flush) begin
            mdl_q.delete();
            mdl_t.delete();
            mdl_rdy  = 1'b1;
            mdl_wptr = 0;
        end else begin
            if (cur_pop) begin
                void'(mdl_q.pop_front());
                void'(mdl_t.pop_front());
            end
            if (cur_push) begin
                mdl_q.push_back(cur_data);
                mdl_t.push_back(edge_cnt);
                mdl_wptr = (mdl_wptr + 1) % DEPTH;
            end
            mdl_rdy = (mdl_q.size() < CAP);
        end
        @(negedge clk);
        checkOutput("in_ready", DW'(in_ready), DW'(mdl_rdy));
        checkOutput("out_valid", DW'(out_valid), DW'(mdl_valid()));
        checkOutput("fill_level", DW'(fill_level), DW'(mdl_q.size()));
        checkOutput("almost_full", DW'(almost_full), DW'(mdl_q.size() >= AFULL));
        if (mdl_valid()) checkOutput("out_data", out_data, mdl_q[0]);
    endtask

    task automatic runCycle(input bit iv, input logic [DW-1:0] d, input bit ordy, input bit fl);
        applyStimulus(iv, d, ordy, fl);
        commitCycle();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [DW-1:0] d;
        int            valid_cycles;
        int            gaps;
        bit            started;

        errors   = 0;
        checks   = 0;
        edge_cnt = 0;
        mdl_rdy  = 1'b0;
        mdl_wptr = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;

        // Reset held for three cycles, then released away from the edge
        for (int i = 0; i < 3; i++) runCycle(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready_pre", DW'(in_ready), DW'(0));
        runCycle(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rst_in_ready_post", DW'(in_ready), DW'(1));
        $display("[TB] reset sequence done");

        // Cut-through into an empty block
        applyStimulus(1'b1, DW'(68'hA5), 1'b1, 1'b0);
        checkOutput("ct_raddr", DW'(ram_raddr), DW'(0));
        checkOutput("ct_waddr", DW'(ram_waddr), DW'(0));
        commitCycle();
        checkOutput("ct_valid_n", DW'(out_valid), DW'(0));
        runCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput("ct_valid_n1", DW'(out_valid), DW'(1));
        checkOutput("ct_data", out_data, DW'(68'hA5));
        runCycle(1'b0, '0, 1'b1, 1'b0);

        // Fill to capacity, overflow attempt, then drain in order
        for (int k = 1; k <= CAP; k++) runCycle(1'b1, DW'(k), 1'b0, 1'b0);
        checkOutput("fill_ready", DW'(in_ready), DW'(0));
        checkOutput("fill_level18", DW'(fill_level), DW'(18));
        runCycle(1'b1, DW'(99), 1'b0, 1'b0);
        checkOutput("fill_overflow", DW'(fill_level), DW'(18));
        for (int k = 1; k <= CAP; k++) begin
            checkOutput("drain_valid", DW'(out_valid), DW'(1));
            checkOutput("drain_order", out_data, DW'(k));
            runCycle(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("drain_empty", DW'(fill_level), DW'(0));

        // Streaming: push and pop every cycle
        valid_cycles = 0;
        gaps         = 0;
        started      = 1'b0;
        for (int i = 0; i < 100; i++) begin
            runCycle(1'b1, DW'(1000 + i), 1'b1, 1'b0);
            if (out_valid) begin
                valid_cycles++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
        end
        checkOutput("stream_gaps", DW'(gaps), DW'(0));
        checkOutput("stream_valid_cycles", DW'(valid_cycles), DW'(99));
        for (int i = 0; i < 4; i++) runCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput("stream_drained", DW'(fill_level), DW'(0));

        // Random backpressure with occasional flush and one mid-run reset
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst_n = 1'b0;
                #1;
                checkOutput("async_rst_valid", DW'(out_valid), DW'(0));
                checkOutput("async_rst_fill", DW'(fill_level), DW'(0));
                checkOutput("async_rst_ready", DW'(in_ready), DW'(0));
                runCycle(1'b0, '0, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            d = {4'($urandom), $urandom, $urandom};
            runCycle(1'($urandom), d, 1'($urandom), ($urandom_range(0, 199) == 0));
        end
        for (int i = 0; i < 24; i++) runCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput("rand_drained", DW'(fill_level), DW'(0));

        // Flush with tickets queued and a read in flight
        for (int k = 1; k <= 8; k++) runCycle(1'b1, DW'(k), 1'b0, 1'b0);
        runCycle(1'b0, '0, 1'b1, 1'b0);
        checkOutput("pre_flush_fill", DW'(fill_level), DW'(7));
        runCycle(1'b1, DW'(68'h77), 1'b1, 1'b1);
        checkOutput("flush_valid", DW'(out_valid), DW'(0));
        checkOutput("flush_fill", DW'(fill_level), DW'(0));
        checkOutput("flush_ready", DW'(in_ready), DW'(1));
        runCycle(1'b1, DW'(68'h3C), 1'b0, 1'b0);
        runCycle(1'b0, '0, 1'b0, 1'b0);
        checkOutput("post_flush_valid", DW'(out_valid), DW'(1));
        checkOutput("post_flush_data", out_data, DW'(68'h3C));
        runCycle(1'b0, '0, 1'b0, 1'b0);
        checkOutput("post_flush_hold", out_data, DW'(68'h3C));
        checkOutput("post_flush_fill", DW'(fill_level), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
